// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic light family: RGY phase codes and
// seven-segment (gfedcba, active-high) glyph constants.
package traffic_pkg;

  typedef enum logic [2:0] {
    RGY_OFF    = 3'b000,
    RGY_YELLOW = 3'b001,
    RGY_GREEN  = 3'b010,
    RGY_RED    = 3'b100
  } phase_e;

  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1101111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Single-digit seven-segment decoder; non-decimal codes or dash_i show a dash.
module seg7_decoder
  import traffic_pkg::*;
(
  input  logic [3:0] value_i,
  input  logic       dash_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    if (!dash_i) begin
      case (value_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/traffic_countdown.sv
// Tracks the controller's current RGY phase and cycles remaining in it, and
// drives a countdown digit, pedestrian lamps and an illegal-combination flag.
module traffic_countdown
  import traffic_pkg::*;
#(
  parameter int unsigned R_CYCLES = 5,
  parameter int unsigned G_CYCLES = 3,
  parameter int unsigned Y_CYCLES = 1,
  parameter int unsigned FLASH_TH = 2,
  parameter int unsigned CW       = 4
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Red,
  input  logic          Green,
  input  logic          Yellow,
  output logic [CW-1:0] Remain,
  output logic [6:0]    Seg7,
  output logic          Walk,
  output logic          Dont_Walk,
  output logic          Phase_Error
);

  localparam int unsigned CW_MAX = (CW >= 4) ? 32'd15 : ((32'd1 << CW) - 32'd1);

  if (CW < 1 ||
      R_CYCLES < 1 || R_CYCLES > 10 || R_CYCLES > CW_MAX ||
      G_CYCLES < 1 || G_CYCLES > 10 || G_CYCLES > CW_MAX ||
      Y_CYCLES < 1 || Y_CYCLES > 10 || Y_CYCLES > CW_MAX) begin : g_bad_params
    $error("traffic_countdown: *_CYCLES must be 1..10 and fit in CW bits");
  end

  logic [2:0]    rgy;
  phase_e        phase_q, phase_d;
  logic [CW-1:0] remain_q, remain_d;
  logic          err_q, err_d;

  assign rgy = {Red, Green, Yellow};

  // A one-hot code differing from the held phase (including after an error,
  // where phase is OFF) is always a fresh entry, so early switches reload.
  always_comb begin
    phase_d  = phase_q;
    remain_d = remain_q;
    err_d    = err_q;
    if (!is_onehot3(rgy)) begin
      err_d    = 1'b1;
      phase_d  = RGY_OFF;
      remain_d = '0;
    end else if (rgy != phase_q) begin
      err_d   = 1'b0;
      phase_d = phase_e'(rgy);
      case (rgy)
        3'b100:  remain_d = CW'(R_CYCLES - 1);
        3'b010:  remain_d = CW'(G_CYCLES - 1);
        default: remain_d = CW'(Y_CYCLES - 1);
      endcase
    end else if (remain_q != '0) begin
      remain_d = remain_q - CW'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      phase_q  <= RGY_OFF;
      remain_q <= '0;
      err_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      remain_q <= remain_d;
      err_q    <= err_d;
    end
  end

  logic [3:0] digit;
  logic       dash;

  assign digit = 4'(remain_q);
  assign dash  = err_q || (32'(remain_q) > 32'd9);

  seg7_decoder u_seg7 (
    .value_i (digit),
    .dash_i  (dash),
    .seg_o   (Seg7)
  );

  always_comb begin
    Walk      = 1'b0;
    Dont_Walk = 1'b1;
    if (!err_q && phase_q == RGY_RED) begin
      if (32'(remain_q) > FLASH_TH) begin
        Walk      = 1'b1;
        Dont_Walk = 1'b0;
      end else begin
        Dont_Walk = remain_q[0];
      end
    end
  end

  assign Remain      = remain_q;
  assign Phase_Error = err_q;

endmodule

// File: tb/tb_traffic_countdown.sv
// Scoreboard bench for traffic_countdown: directed RGY vectors push expected
// post-edge outputs; a negedge monitor pops and compares them.
module tb_traffic_countdown;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Red, Green, Yellow;
  logic [3:0] Remain;
  logic [6:0] Seg7;
  logic       Walk, Dont_Walk, Phase_Error;

  localparam logic [6:0] S0 = 7'b0111111;
  localparam logic [6:0] S1 = 7'b0000110;
  localparam logic [6:0] S2 = 7'b1011011;
  localparam logic [6:0] S3 = 7'b1001111;
  localparam logic [6:0] S4 = 7'b1100110;
  localparam logic [6:0] SD = 7'b1000000;

  traffic_countdown #(
    .R_CYCLES (5),
    .G_CYCLES (3),
    .Y_CYCLES (1),
    .FLASH_TH (2),
    .CW       (4)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Red         (Red),
    .Green       (Green),
    .Yellow      (Yellow),
    .Remain      (Remain),
    .Seg7        (Seg7),
    .Walk        (Walk),
    .Dont_Walk   (Dont_Walk),
    .Phase_Error (Phase_Error)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  rem;
    logic [6:0]  seg;
    logic        walk;
    logic        dw;
    logic        err;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cycle_cnt = 0;
  int          pass_cnt  = 0;
  int          chk_cnt   = 0;

  always @(posedge Clock) cycle_cnt <= cycle_cnt + 1;

  always @(negedge Clock) begin
    while (sb.size() > 0 && sb[0].cyc <= cycle_cnt) begin
      exp_t e;
      e = sb.pop_front();
      chk_cnt = chk_cnt + 1;
      if ({Remain, Seg7, Walk, Dont_Walk, Phase_Error} ===
          {e.rem, e.seg, e.walk, e.dw, e.err})
        pass_cnt = pass_cnt + 1;
      else
        $display("FAIL %s: got rem=%0d seg=%b walk=%b dw=%b err=%b, expected rem=%0d seg=%b walk=%b dw=%b err=%b",
                 e.name, Remain, Seg7, Walk, Dont_Walk, Phase_Error,
                 e.rem, e.seg, e.walk, e.dw, e.err);
    end
  end

  // Apply inputs for the next edge and queue what that edge must produce.
  task automatic step(input logic rst, input logic [2:0] rgy, input logic [3:0] rem,
                      input logic [6:0] seg, input logic w, input logic dw,
                      input logic err, input string nm);
    exp_t e;
    Reset = rst;
    {Red, Green, Yellow} = rgy;
    e.cyc = cycle_cnt + 1; e.rem = rem; e.seg = seg;
    e.walk = w; e.dw = dw; e.err = err; e.name = nm;
    sb.push_back(e);
    @(posedge Clock);
    #1;
  endtask

  initial begin
    step(1, 3'b000, 0, S0, 0, 1, 0, "reset0");
    step(1, 3'b000, 0, S0, 0, 1, 0, "reset1");
    step(0, 3'b100, 4, S4, 1, 0, 0, "red_r4");
    step(0, 3'b100, 3, S3, 1, 0, 0, "red_r3");
    step(0, 3'b100, 2, S2, 0, 0, 0, "red_r2_flash");
    step(0, 3'b100, 1, S1, 0, 1, 0, "red_r1_flash");
    step(0, 3'b100, 0, S0, 0, 0, 0, "red_r0_flash");
    step(0, 3'b010, 2, S2, 0, 1, 0, "green_r2");
    step(0, 3'b010, 1, S1, 0, 1, 0, "green_r1");
    step(0, 3'b010, 0, S0, 0, 1, 0, "green_r0");
    step(0, 3'b001, 0, S0, 0, 1, 0, "yellow_r0");
    step(0, 3'b100, 4, S4, 1, 0, 0, "red_reentry");
    step(0, 3'b010, 2, S2, 0, 1, 0, "ghold_r2");
    step(0, 3'b010, 1, S1, 0, 1, 0, "ghold_r1");
    step(0, 3'b010, 0, S0, 0, 1, 0, "ghold_r0");
    step(0, 3'b010, 0, S0, 0, 1, 0, "ghold_sat1");
    step(0, 3'b010, 0, S0, 0, 1, 0, "ghold_sat2");
    step(0, 3'b010, 0, S0, 0, 1, 0, "ghold_sat3");
    step(0, 3'b110, 0, SD, 0, 1, 1, "illegal_110");
    step(0, 3'b000, 0, SD, 0, 1, 1, "illegal_000");
    step(0, 3'b100, 4, S4, 1, 0, 0, "recover_red");
    step(0, 3'b111, 0, SD, 0, 1, 1, "illegal_111");
    step(0, 3'b001, 0, S0, 0, 1, 0, "recover_yellow");
    step(0, 3'b010, 2, S2, 0, 1, 0, "green_pre");
    step(0, 3'b100, 4, S4, 1, 0, 0, "red_c1");
    step(0, 3'b100, 3, S3, 1, 0, 0, "red_c2");
    step(1, 3'b100, 0, S0, 0, 1, 0, "reset_mid_red");
    step(0, 3'b100, 4, S4, 1, 0, 0, "post_reset_red");
    step(0, 3'b100, 3, S3, 1, 0, 0, "red_again_r3");
    step(0, 3'b100, 2, S2, 0, 0, 0, "red_again_r2");
    step(0, 3'b010, 2, S2, 0, 1, 0, "early_green");
    step(0, 3'b010, 1, S1, 0, 1, 0, "early_green_r1");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge Clock);
    #6;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      chk_cnt = chk_cnt + sb.size();
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
